board_renderer: RTL and testbench

Pixel-to-cell renderer directly upstream of the colour mapper. It holds the 10×20 Tetris playfield, overlays the falling 4×4 piece, and turns each VGA pixel coordinate (DrawX, DrawY) into a 3-bit cell code plus in-board and edge flags. The results come out through a 2-stage pipeline, and the colour mapper converts them to RGB. It also provides the write port used by game logic, a board-clear sequencer and per-row full flags.

---
 rtl/tetris_pkg.sv | 26 ++
 rtl/board_ram.sv | 73 +++++++
 rtl/board_renderer.sv | 202 ++++++++++++++++++++
 tb/tb_board_renderer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/tetris_pkg.sv
// Shared Tetris definitions: board geometry, cell type, clear FSM states
// and a small helper for the 4x4 piece window test.
package tetris_pkg;

    localparam int BOARD_COLS = 10;
    localparam int BOARD_ROWS = 20;
    localparam int BOARD_X0   = 240;
    localparam int BOARD_Y0   = 80;
    localparam int CELL_SHIFT = 4;
    localparam int BOARD_W    = BOARD_COLS << CELL_SHIFT;
    localparam int BOARD_H    = BOARD_ROWS << CELL_SHIFT;

    typedef logic [2:0] cell_t;
    localparam cell_t CELL_EMPTY = 3'd0;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

    // A 7-bit signed offset lies in the 0..3 piece window when bits [6:2] are all zero.
    function automatic logic in_window(input logic [6:0] d);
        return (d[6:2] == 5'd0);
    endfunction

endpackage

// File: rtl/board_ram.sv
// Playfield storage: 20x10 cell array with a write port, a whole-row clear
// port, one asynchronous read port and registered per-row full flags.
module board_ram
    import tetris_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        i_wr_en,
    input  logic [3:0]  i_wr_col,
    input  logic [4:0]  i_wr_row,
    input  logic [2:0]  i_wr_data,
    input  logic        i_clr_en,
    input  logic [4:0]  i_clr_row,
    input  logic [3:0]  i_rd_col,
    input  logic [4:0]  i_rd_row,
    output logic [2:0]  o_rd_data,
    output logic [19:0] o_row_full
);

    cell_t       r_board [BOARD_ROWS][BOARD_COLS];
    logic [19:0] w_full;
    logic [19:0] r_row_full;

    // Cell storage update: a row clear wins, otherwise a (pre-qualified) write.
    always_ff @(posedge Clk) begin
        if (i_clr_en && (i_clr_row < 5'(BOARD_ROWS))) begin
            for (int c = 0; c < BOARD_COLS; c++) begin
                r_board[i_clr_row][c] <= CELL_EMPTY;
            end
        end else if (i_wr_en && (i_wr_row < 5'(BOARD_ROWS)) && (i_wr_col < 4'(BOARD_COLS))) begin
            r_board[i_wr_row][i_wr_col] <= i_wr_data;
        end else begin
            r_board <= r_board;
        end
    end

    // Asynchronous read; addresses outside the board read as empty.
    always_comb begin
        o_rd_data = CELL_EMPTY;
        if ((i_rd_row < 5'(BOARD_ROWS)) && (i_rd_col < 4'(BOARD_COLS))) begin
            o_rd_data = r_board[i_rd_row][i_rd_col];
        end else begin
            o_rd_data = CELL_EMPTY;
        end
    end

    // A row is full when none of its cells is empty.
    always_comb begin
        w_full = 20'd0;
        for (int r = 0; r < BOARD_ROWS; r++) begin
            w_full[r] = 1'b1;
            for (int c = 0; c < BOARD_COLS; c++) begin
                if (r_board[r][c] == CELL_EMPTY) begin
                    w_full[r] = 1'b0;
                end else begin
                    w_full[r] = w_full[r];
                end
            end
        end
    end

    // Row-full flags lag the board by one edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_row_full <= 20'd0;
        end else begin
            r_row_full <= w_full;
        end
    end

    assign o_row_full = r_row_full;

endmodule

// File: rtl/board_renderer.sv
// Board renderer: 2-stage pixel-to-cell pipeline with falling-piece overlay,
// game-logic write port and a row-per-cycle board clear sequencer.
// Optional macro CELL_EDGE_EN builds the per-cell 1-px edge flag; without it
// pix_edge is tied low.
module board_renderer
    import tetris_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        wr_en,
    input  logic [3:0]  wr_col,
    input  logic [4:0]  wr_row,
    input  logic [2:0]  wr_data,
    input  logic        clear_start,
    input  logic [4:0]  piece_x,
    input  logic [5:0]  piece_y,
    input  logic [15:0] piece_mask,
    input  logic [2:0]  piece_color,
    output logic        busy,
    output logic [19:0] row_full,
    output logic        pix_in_board,
    output logic [2:0]  pix_cell,
    output logic        pix_edge
);

    // ---------------- clear sequencer ----------------
    clr_state_t r_state;
    clr_state_t w_state_nxt;
    logic [4:0] r_rowcnt;
    logic       w_busy;
    logic       w_clr_en;
    logic       w_wr_ok;

    // State register; reset behaves as a clear request starting at row 0.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: start on request, leave after the last row is zeroed.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  w_state_nxt = clear_start ? ST_CLEAR : ST_IDLE;
            ST_CLEAR: w_state_nxt = (r_rowcnt == 5'(BOARD_ROWS - 1)) ? ST_IDLE : ST_CLEAR;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: busy and row-clear enable exactly while clearing.
    always_comb begin
        w_busy   = 1'b0;
        w_clr_en = 1'b0;
        case (r_state)
            ST_IDLE:  begin w_busy = 1'b0; w_clr_en = 1'b0; end
            ST_CLEAR: begin w_busy = 1'b1; w_clr_en = 1'b1; end
            default:  begin w_busy = 1'b0; w_clr_en = 1'b0; end
        endcase
    end

    // Row counter: held at 0 while idle, so a new clear always starts at row 0.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_rowcnt <= 5'd0;
        end else if ((r_state == ST_IDLE) || (r_rowcnt == 5'(BOARD_ROWS - 1))) begin
            r_rowcnt <= 5'd0;
        end else begin
            r_rowcnt <= r_rowcnt + 5'd1;
        end
    end

    assign busy    = w_busy;
    assign w_wr_ok = wr_en && !w_busy && (wr_col < 4'(BOARD_COLS)) && (wr_row < 5'(BOARD_ROWS));

    // ---------------- pixel stage 1 ----------------
    logic [10:0] w_rx;
    logic [10:0] w_ry;
    logic        w_in_board;
    logic        r1_in;
    logic [3:0]  r1_col;
    logic [4:0]  r1_row;
    logic [4:0]  r1_px;
    logic [5:0]  r1_py;
    logic [15:0] r1_mask;
    logic [2:0]  r1_color;

    // Board-relative coordinates; bit 10 is the sign.
    assign w_rx       = {1'b0, DrawX} - 11'(BOARD_X0);
    assign w_ry       = {1'b0, DrawY} - 11'(BOARD_Y0);
    assign w_in_board = !w_rx[10] && (w_rx < 11'(BOARD_W)) && !w_ry[10] && (w_ry < 11'(BOARD_H));

    // Stage 1 registers: cell address, in-board flag and a snapshot of the piece.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r1_in    <= 1'b0;
            r1_col   <= 4'd0;
            r1_row   <= 5'd0;
            r1_px    <= 5'd0;
            r1_py    <= 6'd0;
            r1_mask  <= 16'd0;
            r1_color <= 3'd0;
        end else begin
            r1_in    <= w_in_board;
            r1_col   <= w_rx[CELL_SHIFT +: 4];
            r1_row   <= w_ry[CELL_SHIFT +: 5];
            r1_px    <= piece_x;
            r1_py    <= piece_y;
            r1_mask  <= piece_mask;
            r1_color <= piece_color;
        end
    end

    // ---------------- pixel stage 2 ----------------
    logic [6:0] w_dc;
    logic [6:0] w_dr;
    logic       w_hit;
    logic [2:0] w_board_cell;
    logic [2:0] w_cell;
    logic       r_pix_in;
    logic [2:0] r_pix_cell;

    board_ram u_board_ram (
        .Clk        (Clk),
        .Reset      (Reset),
        .i_wr_en    (w_wr_ok),
        .i_wr_col   (wr_col),
        .i_wr_row   (wr_row),
        .i_wr_data  (wr_data),
        .i_clr_en   (w_clr_en),
        .i_clr_row  (r_rowcnt),
        .i_rd_col   (r1_col),
        .i_rd_row   (r1_row),
        .o_rd_data  (w_board_cell),
        .o_row_full (row_full)
    );

    // Offsets of this cell from the piece origin (signed 7-bit).
    assign w_dc  = {3'b000, r1_col} - {{2{r1_px[4]}}, r1_px};
    assign w_dr  = {2'b00, r1_row}  - {r1_py[5], r1_py};
    assign w_hit = in_window(w_dc) && in_window(w_dr) && r1_mask[{w_dr[1:0], w_dc[1:0]}];

    // Cell selection: piece overlays board; outside the board everything is 0.
    always_comb begin
        w_cell = CELL_EMPTY;
        if (!r1_in) begin
            w_cell = CELL_EMPTY;
        end else if (w_hit) begin
            w_cell = r1_color;
        end else begin
            w_cell = w_board_cell;
        end
    end

    // Stage 2 output registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_pix_in   <= 1'b0;
            r_pix_cell <= 3'd0;
        end else begin
            r_pix_in   <= r1_in;
            r_pix_cell <= w_cell;
        end
    end

    assign pix_in_board = r_pix_in;
    assign pix_cell     = r_pix_cell;

`ifdef CELL_EDGE_EN
    logic [CELL_SHIFT-1:0] w_sub_x;
    logic [CELL_SHIFT-1:0] w_sub_y;
    logic                  w_edge1;
    logic                  r1_edge;
    logic                  r_pix_edge;

    assign w_sub_x = w_rx[CELL_SHIFT-1:0];
    assign w_sub_y = w_ry[CELL_SHIFT-1:0];
    assign w_edge1 = w_in_board &&
                     ((w_sub_x == {CELL_SHIFT{1'b0}}) || (w_sub_x == {CELL_SHIFT{1'b1}}) ||
                      (w_sub_y == {CELL_SHIFT{1'b0}}) || (w_sub_y == {CELL_SHIFT{1'b1}}));

    // Edge flag pipeline: computed in stage 1, carried through stage 2.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r1_edge    <= 1'b0;
            r_pix_edge <= 1'b0;
        end else begin
            r1_edge    <= w_edge1;
            r_pix_edge <= r1_edge;
        end
    end

    assign pix_edge = r_pix_edge;
`else
    assign pix_edge = 1'b0;
`endif

endmodule

// File: tb/tb_board_renderer.sv
// Scoreboard bench for board_renderer: pixel expectations are queued at issue
// time and popped by a monitor when the 2-cycle pipeline presents them.
module tb_board_renderer;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [9:0]  DrawX = 10'd0;
    logic [9:0]  DrawY = 10'd0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_col = 4'd0;
    logic [4:0]  wr_row = 5'd0;
    logic [2:0]  wr_data = 3'd0;
    logic        clear_start = 1'b0;
    logic [4:0]  piece_x = 5'd0;
    logic [5:0]  piece_y = 6'd0;
    logic [15:0] piece_mask = 16'd0;
    logic [2:0]  piece_color = 3'd0;
    logic        busy;
    logic [19:0] row_full;
    logic        pix_in_board;
    logic [2:0]  pix_cell;
    logic        pix_edge;

`ifdef CELL_EDGE_EN
    localparam logic EDGE_ON = 1'b1;
`else
    localparam logic EDGE_ON = 1'b0;
`endif

    int         n_cmp = 0;
    int         n_err = 0;
    logic [4:0] exp_q [$];
    logic [4:0] mon_e;
    logic       tb_vld = 1'b0;
    logic [1:0] v_pipe = 2'b00;
    int         nb;

    board_renderer dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .wr_en       (wr_en),
        .wr_col      (wr_col),
        .wr_row      (wr_row),
        .wr_data     (wr_data),
        .clear_start (clear_start),
        .piece_x     (piece_x),
        .piece_y     (piece_y),
        .piece_mask  (piece_mask),
        .piece_color (piece_color),
        .busy        (busy),
        .row_full    (row_full),
        .pix_in_board(pix_in_board),
        .pix_cell    (pix_cell),
        .pix_edge    (pix_edge)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Track which cycles carry a scored pixel through the 2-stage pipeline.
    always @(posedge Clk) v_pipe <= {v_pipe[0], tb_vld};

    // Monitor: compare DUT pixel outputs against the queued expectations.
    always @(negedge Clk) begin
        if (v_pipe[1]) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL scoreboard_underflow: got output with no expectation queued");
            end else begin
                mon_e = exp_q.pop_front();
                check("pix_in_board", {31'd0, pix_in_board}, {31'd0, mon_e[4]});
                check("pix_cell", {29'd0, pix_cell}, {29'd0, mon_e[3:1]});
                check("pix_edge", {31'd0, pix_edge}, {31'd0, mon_e[0]});
            end
        end
    end

    task automatic pix(input int x, input int y, input logic ein, input logic [2:0] ecell,
                       input logic egeom);
        DrawX  = 10'(x);
        DrawY  = 10'(y);
        tb_vld = 1'b1;
        exp_q.push_back({ein, ecell, egeom & EDGE_ON});
        @(posedge Clk); #1;
    endtask

    task automatic drain();
        tb_vld = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
    endtask

    task automatic wr(input int c, input int r, input int d);
        wr_en   = 1'b1;
        wr_col  = 4'(c);
        wr_row  = 5'(r);
        wr_data = 3'(d);
        @(posedge Clk); #1;
        wr_en = 1'b0;
    endtask

    // Count cycles with busy high (bounded); optionally inject a write and a
    // second clear request while busy.
    task automatic count_busy(input bit inject, output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            if (inject && n == 5) begin
                wr_en = 1'b1; wr_col = 4'd2; wr_row = 5'd2; wr_data = 3'd6;
            end
            if (inject && n == 10) clear_start = 1'b1;
            @(posedge Clk); #1;
            wr_en = 1'b0;
            clear_start = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held for several cycles
        repeat (3) @(posedge Clk);
        #1;
        check("reset_pix_in_board", {31'd0, pix_in_board}, 32'd0);
        check("reset_pix_cell", {29'd0, pix_cell}, 32'd0);
        check("reset_pix_edge", {31'd0, pix_edge}, 32'd0);
        check("reset_row_full", {12'd0, row_full}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd1);
        Reset = 1'b0;
        count_busy(1'b0, nb);
        check("reset_clear_cycles", nb, 32'd20);
        check("post_reset_row_full", {12'd0, row_full}, 32'd0);

        // Single write and in-cell pixels
        wr(3, 5, 4);
        pix(240 + 53, 80 + 85, 1'b1, 3'd4, 1'b0);
        pix(240 + 48, 80 + 85, 1'b1, 3'd4, 1'b1);
        // Outside the board
        pix(239, 165, 1'b0, 3'd0, 1'b0);
        pix(400, 165, 1'b0, 3'd0, 1'b0);
        pix(300, 400, 1'b0, 3'd0, 1'b0);
        // Last pixel of the board: col 9 row 19, sub 15/15
        pix(399, 399, 1'b1, 3'd0, 1'b1);
        drain();

        // Piece at (-1, 2), mask bit 5 -> cell col 0 row 3
        piece_x = 5'b11111; piece_y = 6'd2; piece_mask = 16'h0020; piece_color = 3'd7;
        pix(240 + 5, 80 + 53, 1'b1, 3'd7, 1'b0);
        pix(240 + 21, 80 + 53, 1'b1, 3'd0, 1'b0);
        pix(240 + 5, 80 + 21, 1'b1, 3'd0, 1'b0);
        pix(240 + 53, 80 + 85, 1'b1, 3'd4, 1'b0);
        // Piece at (2, 4), mask bit 5 -> covers col 3 row 5 over the board value
        piece_x = 5'd2; piece_y = 6'd4; piece_color = 3'd2;
        pix(240 + 53, 80 + 85, 1'b1, 3'd2, 1'b0);
        drain();
        piece_mask = 16'd0;

        // Fill row 19, row_full lags one edge
        for (int c = 0; c < 10; c++) wr(c, 19, (c % 7) + 1);
        check("row_full_lag", {12'd0, row_full}, 32'd0);
        @(posedge Clk); #1;
        check("row_full_19", {12'd0, row_full}, 32'h80000);
        pix(399, 399, 1'b1, 3'd3, 1'b1);
        drain();

        // Clear with a second request and a write while busy
        clear_start = 1'b1;
        @(posedge Clk); #1;
        clear_start = 1'b0;
        count_busy(1'b1, nb);
        check("clear_cycles", nb, 32'd20);
        check("row_full_clear_lag", {12'd0, row_full}, 32'h80000);
        @(posedge Clk); #1;
        check("row_full_cleared", {12'd0, row_full}, 32'd0);
        pix(240 + 53, 80 + 85, 1'b1, 3'd0, 1'b0);
        pix(240 + 37, 80 + 37, 1'b1, 3'd0, 1'b0);
        pix(399, 399, 1'b1, 3'd0, 1'b1);
        drain();

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
